// File: rtl/sdram_pkg.sv
// Shared SDRAM constants and writer FSM state encoding used by the burst writer
// and anything else that talks to the de10_lite_sdram controller.
package sdram_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    localparam int SDRAM_BANK_W = 2;
    localparam int SDRAM_ROW_W  = 13;
    localparam int SDRAM_COL_W  = 10;
    localparam int SDRAM_ADDR_W = SDRAM_BANK_W + SDRAM_ROW_W + SDRAM_COL_W;

    typedef enum logic [2:0] {
        WR_IDLE   = 3'd0,
        WR_FILL   = 3'd1,
        WR_CMD    = 3'd2,
        WR_ACK    = 3'd3,
        WR_STREAM = 3'd4,
        WR_GAP    = 3'd5
    } wr_state_e;

endpackage

// File: rtl/sdram_burst_writer_if.sv
// Bundle of the writer's control, stream and controller-side signals.
// slave is the writer's view, master is the view of whoever drives it.
interface sdram_burst_writer_if #(
    parameter int AddrWidth = 25,
    parameter int DataWidth = 16
);
    logic                 start_i;
    logic [AddrWidth-1:0] base_addr_i;
    logic [15:0]          burst_count_i;
    logic [DataWidth-1:0] s_data_i;
    logic                 s_valid_i;
    logic                 s_ready_o;
    logic [1:0]           command_o;
    logic [AddrWidth-1:0] data_address_o;
    logic [DataWidth-1:0] data_write_o;
    logic                 data_write_done_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 error_o;

    modport slave (
        input  start_i, base_addr_i, burst_count_i, s_data_i, s_valid_i, data_write_done_i,
        output s_ready_o, command_o, data_address_o, data_write_o, busy_o, done_o, error_o
    );

    modport master (
        output start_i, base_addr_i, burst_count_i, s_data_i, s_valid_i, data_write_done_i,
        input  s_ready_o, command_o, data_address_o, data_write_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and flush.
// Push on a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DataWidth = 16,
    parameter int Depth     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic                   pop_i,
    output logic [DataWidth-1:0]   data_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o
);
    localparam int PtrW = $clog2(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q;
    logic                 empty, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_burst_writer.sv
// Buffers a word stream and replays it to the SDRAM controller as full-length
// burst writes at an auto-incrementing address; pulses done when all bursts are out.
module sdram_burst_writer
    import sdram_pkg::*;
#(
    parameter int BurstLength = 8,
    parameter int AddrWidth   = SDRAM_ADDR_W,
    parameter int DataWidth   = 16,
    parameter int FifoDepth   = 16,
    parameter int AckTimeout  = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sdram_burst_writer_if.slave  bus
);
    localparam int TotW  = 16 + 3;
    localparam int BeatW = $clog2(BurstLength) + 1;
    localparam int TmrW  = $clog2(AckTimeout + 1);
    localparam int FcW   = $clog2(FifoDepth) + 1;

    wr_state_e            state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          bursts_q, bursts_d;
    logic [TotW-1:0]      total_q, total_d;
    logic [TotW-1:0]      accepted_q, accepted_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic                 gap_q, gap_d;
    logic [TmrW-1:0]      tmr_q, tmr_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;

    logic                 busy, push, pop, flush, full;
    logic [DataWidth-1:0] head;
    logic [FcW-1:0]       fill;

    assign busy  = (state_q != WR_IDLE);
    assign push  = bus.s_valid_i && bus.s_ready_o;
    assign pop   = (state_q == WR_STREAM) || (state_q == WR_ACK && bus.data_write_done_i);
    assign flush = (state_q == WR_ACK) && !bus.data_write_done_i &&
                   (tmr_q == TmrW'(AckTimeout - 1));

    sync_fifo #(
        .DataWidth (DataWidth),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (bus.s_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fill),
        .full_o  (full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bursts_d   = bursts_q;
        total_d    = total_q;
        accepted_d = accepted_q + TotW'(push);
        beat_d     = beat_q;
        gap_d      = gap_q;
        tmr_d      = tmr_q;
        error_d    = error_q;
        done_d     = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (bus.start_i) begin
                    addr_d     = bus.base_addr_i;
                    bursts_d   = bus.burst_count_i;
                    total_d    = TotW'(bus.burst_count_i) << $clog2(BurstLength);
                    accepted_d = '0;
                    error_d    = 1'b0;
                    if (bus.burst_count_i == '0) done_d = 1'b1;
                    else                         state_d = WR_FILL;
                end
            end
            WR_FILL: begin
                if (fill >= FcW'(BurstLength)) state_d = WR_CMD;
            end
            WR_CMD: begin
                tmr_d   = TmrW'(1);
                state_d = WR_ACK;
            end
            WR_ACK: begin
                if (bus.data_write_done_i) begin
                    beat_d  = BeatW'(1);
                    gap_d   = 1'b0;
                    state_d = (BurstLength == 1) ? WR_GAP : WR_STREAM;
                end else if (tmr_q == TmrW'(AckTimeout - 1)) begin
                    // Controller is presumed dead: drop the buffered data, no done.
                    error_d = 1'b1;
                    state_d = WR_IDLE;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            WR_STREAM: begin
                beat_d = beat_q + BeatW'(1);
                if (beat_q == BeatW'(BurstLength - 1)) begin
                    gap_d   = 1'b0;
                    state_d = WR_GAP;
                end
            end
            WR_GAP: begin
                gap_d = 1'b1;
                if (gap_q) begin
                    addr_d   = addr_q + AddrWidth'(BurstLength);
                    bursts_d = bursts_q - 16'd1;
                    if (bursts_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = WR_IDLE;
                    end else begin
                        state_d = WR_FILL;
                    end
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= WR_IDLE;
            addr_q     <= '0;
            bursts_q   <= '0;
            total_q    <= '0;
            accepted_q <= '0;
            beat_q     <= '0;
            gap_q      <= 1'b0;
            tmr_q      <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bursts_q   <= bursts_d;
            total_q    <= total_d;
            accepted_q <= accepted_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            tmr_q      <= tmr_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    // Outputs decode from registered state so reset clears them immediately.
    assign bus.command_o      = (state_q == WR_CMD) ? CMD_WRITE : CMD_IDLE;
    assign bus.data_address_o = (state_q == WR_CMD) ? addr_q : '0;
    assign bus.data_write_o   = (state_q == WR_CMD || state_q == WR_ACK || state_q == WR_STREAM)
                                ? head : '0;
    assign bus.s_ready_o      = busy && !full && (accepted_q < total_q);
    assign bus.busy_o         = busy;
    assign bus.done_o         = done_q;
    assign bus.error_o        = error_q;
endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench: a negedge environment feeds the stream and models the controller ack,
// a sequencer drives transfers and checks the logged commands, words and timing.
module tb_sdram_burst_writer;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_burst_writer_if #(.AddrWidth(25), .DataWidth(16)) bus();

    sdram_burst_writer #(
        .BurstLength (8),
        .AddrWidth   (25),
        .DataWidth   (16),
        .FifoDepth   (16),
        .AckTimeout  (15)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // stimulus config (sequencer-owned)
    logic [15:0] feed [0:31];
    int feed_n = 0;
    bit feed_toggle = 1'b0;
    int ack_lat = 2;
    bit ack_en = 1'b1;
    bit clr_req = 1'b0;

    // log (environment-owned)
    int cyc = 0, feed_idx = 0, ncmd = 0, nwords = 0, done_cnt = 0;
    int done_cyc = -1, err_cyc = -1, start_cyc = -1, bad_cmd = 0, early_cmd = 0;
    int wait_cnt = 0, stream_left = 0;
    bit pend = 1'b0;
    logic [24:0] cmd_addr [0:7];
    logic [15:0] cmd_data [0:7];
    int cmd_cyc [0:7];
    logic [15:0] words [0:31];
    int word_cyc [0:31];

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        bus.data_write_done_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req) begin
                feed_idx = 0; ncmd = 0; nwords = 0; done_cnt = 0; done_cyc = -1; err_cyc = -1;
                bad_cmd = 0; early_cmd = 0; pend = 1'b0; stream_left = 0;
                bus.s_valid_i = 1'b0; bus.data_write_done_i = 1'b0;
            end else if (!rst_n) begin
                pend = 1'b0; stream_left = 0;
                bus.s_valid_i = 1'b0; bus.data_write_done_i = 1'b0;
            end else begin
                if (bus.done_o) begin done_cnt++; done_cyc = cyc; end
                if (bus.error_o && err_cyc < 0) err_cyc = cyc;
                if (bus.start_i) start_cyc = cyc;
                if (bus.command_o == 2'b10) bad_cmd++;
                if (stream_left > 0 && nwords < 32) begin
                    words[nwords] = bus.data_write_o; word_cyc[nwords] = cyc;
                    nwords++; stream_left--;
                end
                bus.data_write_done_i = 1'b0;
                if (bus.command_o == 2'b01) begin
                    if (ncmd < 8) begin
                        cmd_addr[ncmd] = bus.data_address_o;
                        cmd_data[ncmd] = bus.data_write_o;
                        cmd_cyc[ncmd] = cyc;
                    end
                    if (feed_idx < BL * (ncmd + 1)) early_cmd++;
                    ncmd++;
                    pend = ack_en;
                    wait_cnt = ack_lat;
                end else if (pend) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        pend = 1'b0;
                        bus.data_write_done_i = 1'b1;
                        if (nwords < 32) begin
                            words[nwords] = bus.data_write_o; word_cyc[nwords] = cyc; nwords++;
                        end
                        stream_left = BL - 1;
                    end
                end
                bus.s_valid_i = 1'b0;
                if (feed_idx < feed_n && (!feed_toggle || cyc[0])) begin
                    bus.s_valid_i = 1'b1;
                    bus.s_data_i = feed[feed_idx];
                    if (bus.s_ready_o) feed_idx++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic clear_log();
        clr_req = 1'b1;
        @(negedge clk);
        tick();
        clr_req = 1'b0;
    endtask

    task automatic start(input logic [24:0] base, input logic [15:0] cnt);
        bus.base_addr_i = base;
        bus.burst_count_i = cnt;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && done_cnt == 0 && err_cyc < 0; i++) tick();
        tick(3);
    endtask

    task automatic chk_words(input string tag, input int n);
        int bad;
        bad = 0;
        for (int j = 0; j < n; j++) if (words[j] !== feed[j]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int bad;
        bit found;
        bus.start_i = 1'b0;
        bus.base_addr_i = '0;
        bus.burst_count_i = '0;
        tick(2);
        chk("rst_cmd", bus.command_o, 2'b00);
        chk("rst_flags", {bus.s_ready_o, bus.busy_o, bus.done_o, bus.error_o}, 4'b0);
        chk("rst_bus", {bus.data_address_o, bus.data_write_o}, 0);
        rst_n = 1'b1;
        tick(2);

        // single burst
        clear_log();
        for (int j = 0; j < 8; j++) feed[j] = 16'h1111 * 16'(j + 1);
        feed_n = 8; feed_toggle = 1'b0; ack_en = 1'b1; ack_lat = 2;
        start(25'h000100, 16'd1);
        wait_done(200);
        chk("t1_ncmd", ncmd, 1);
        chk("t1_addr", cmd_addr[0], 25'h000100);
        chk("t1_cmd_word0", cmd_data[0], 16'h1111);
        chk("t1_nwords", nwords, 8);
        chk_words("t1_words", 8);
        bad = 0;
        for (int j = 0; j < 8; j++) if (word_cyc[j] != word_cyc[0] + j) bad++;
        chk("t1_word_timing", bad, 0);
        chk("t1_ack_lat", word_cyc[0] - cmd_cyc[0], 2);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_cyc", done_cyc, word_cyc[7] + 3);
        chk("t1_idle", {bus.busy_o, bus.error_o, bus.s_ready_o}, 3'b0);
        chk("t1_no_read", bad_cmd, 0);

        // three bursts wrapping past the top, start pulse while busy
        clear_log();
        for (int j = 0; j < 24; j++) feed[j] = 16'h0F0F + 16'h0123 * 16'(j);
        feed_n = 24; ack_lat = 3;
        start(25'h1FFFFFC, 16'd3);
        for (int i = 0; i < 100 && ncmd == 0; i++) tick();
        start(25'h0000000, 16'd5);
        wait_done(400);
        chk("t2_ncmd", ncmd, 3);
        chk("t2_addr0", cmd_addr[0], 25'h1FFFFFC);
        chk("t2_addr1", cmd_addr[1], 25'h0000004);
        chk("t2_addr2", cmd_addr[2], 25'h000000C);
        chk("t2_spacing", cmd_cyc[1] - cmd_cyc[0], BL + 3 + 3);
        chk("t2_nwords", nwords, 24);
        chk_words("t2_words", 24);
        chk("t2_done_cnt", done_cnt, 1);

        // gappy stream, more words offered than the transfer takes
        clear_log();
        for (int j = 0; j < 20; j++) feed[j] = 16'h5000 + 16'(j * 3);
        feed_n = 20; feed_toggle = 1'b1; ack_lat = 1;
        start(25'h002000, 16'd2);
        wait_done(400);
        feed_toggle = 1'b0;
        chk("t3_early_cmd", early_cmd, 0);
        chk("t3_ncmd", ncmd, 2);
        chk("t3_addr1", cmd_addr[1], 25'h002008);
        chk("t3_nwords", nwords, 16);
        chk_words("t3_words", 16);
        chk("t3_accepted", feed_idx, 16);
        chk("t3_done_cnt", done_cnt, 1);

        // controller never acks
        clear_log();
        for (int j = 0; j < 8; j++) feed[j] = 16'h7700 + 16'(j);
        feed_n = 8; ack_en = 1'b0;
        start(25'h000300, 16'd1);
        for (int i = 0; i < 100 && err_cyc < 0; i++) tick();
        tick(5);
        chk("t4_err_cyc", err_cyc - cmd_cyc[0], 15);
        chk("t4_error", bus.error_o, 1'b1);
        chk("t4_busy", bus.busy_o, 1'b0);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_ncmd", ncmd, 1);

        // zero-length transfer clears error and finishes on the next cycle
        start(25'h000400, 16'd0);
        chk("t6_done_now", bus.done_o, 1'b1);
        chk("t6_err_clr", bus.error_o, 1'b0);
        tick(2);
        chk("t6_done_cyc", done_cyc - start_cyc, 1);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_ncmd", ncmd, 1);
        chk("t6_busy", bus.busy_o, 1'b0);

        // reset while word 4 is on the bus
        clear_log();
        for (int j = 0; j < 8; j++) feed[j] = 16'hB000 + 16'(j);
        feed_n = 8; ack_en = 1'b1; ack_lat = 1;
        start(25'h000500, 16'd1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (nwords > 0 && bus.data_write_o == 16'hB004) found = 1'b1;
        end
        chk("t5_reached_w4", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cmd", bus.command_o, 2'b00);
        chk("t5_rst_bus", {bus.data_address_o, bus.data_write_o}, 0);
        chk("t5_rst_flags", {bus.s_ready_o, bus.busy_o, bus.done_o, bus.error_o}, 4'b0);
        tick(2);
        rst_n = 1'b1;
        tick();
        clear_log();
        for (int j = 0; j < 8; j++) feed[j] = 16'hC000 + 16'(j * 5);
        feed_n = 8;
        start(25'h000600, 16'd1);
        wait_done(200);
        chk("t5_ncmd", ncmd, 1);
        chk("t5_addr", cmd_addr[0], 25'h000600);
        chk("t5_nwords", nwords, 8);
        chk_words("t5_words", 8);
        chk("t5_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_burst_writer.md
# sdram_burst_writer

Upstream feeder for the DE10-Lite SDRAM controller (`de10_lite_sdram`). It accepts a valid/ready stream of 16-bit words for a transfer of N bursts starting at a base address. It buffers the words in a FIFO and drives the controller's write command and data ports so that every burst is a full-length burst write at an auto-incremented address. It pulses `done_o` when the whole transfer has been handed to the controller.

## Interface
- BurstLength, 8: words per burst; must be 1, 2, 4 or 8 and equal to the controller's read burst length (write burst mode ON).
- AddrWidth, 25: SDRAM word address width (bank + row + column).
- DataWidth, 16: word width.
- FifoDepth, 16: buffer depth; must be a power of 2 and at least 2*BurstLength.
- AckTimeout, 15: maximum cycles from WRITE command to `data_write_done_i`.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse; ignored while `busy_o` is high.
- base_addr_i  in  AddrWidth  first word address, latched on start.
- burst_count_i  in  16  number of bursts, latched on start; 0 produces `done_o` on the next cycle with no command issued.
- s_data_i  in  DataWidth  stream data.
- s_valid_i  in  1  stream valid.
- s_ready_o  out  1  stream ready.
- command_o  out  2  to controller: 00 idle, 01 write, 10 read (never driven).
- data_address_o  out  AddrWidth  to controller address.
- data_write_o  out  DataWidth  to controller write data.
- data_write_done_i  in  1  from controller: first word accepted.
- busy_o  out  1  transfer active.
- done_o  out  1  one-cycle pulse at transfer completion.
- error_o  out  1  sticky ack timeout; cleared on the next accepted start.

## Operation
- Reset (asynchronous, while `rst_i` is low) drives every output to 0, flushes the FIFO and puts the FSM in IDLE. Reset mid-burst abandons the burst: `command_o` goes to 00 immediately.
- A stream word is accepted on a cycle with `s_valid_i && s_ready_o`.
- `s_ready_o` = busy AND FIFO not full AND words accepted < burst_count*BurstLength.
- FSM states and transitions:
  - IDLE: on start, latch base address and count, clear `error_o`, go to FILL.
  - FILL: wait until FIFO occupancy >= BurstLength, then go to CMD.
  - CMD: one cycle. `command_o`=01, `data_address_o`=current address, `data_write_o`=FIFO head (word 0). Go to ACK.
  - ACK: `command_o`=00. Word 0 stays on `data_write_o` until `data_write_done_i` is seen high. Then pop word 0 and go to STREAM (or to GAP if BurstLength=1). If AckTimeout cycles pass without the ack, set `error_o`, flush the FIFO and return to IDLE with no `done_o`.
  - STREAM: word j (1..BurstLength-1) is presented on `data_write_o` for exactly one cycle each, popping one word per cycle. After the last word, go to GAP.
  - GAP: 2 idle cycles. Then advance the address by BurstLength and decrement bursts remaining. If bursts remain, go to FILL; otherwise pulse `done_o` and go to IDLE.
- Address arithmetic is modulo 2^AddrWidth; the transfer wraps past the top of memory silently.
- The FIFO accepts writes while a pop is in progress. A simultaneous push and pop on a full FIFO is allowed.

## Timing
- If `data_write_done_i` is sampled high at edge t, word j is on `data_write_o` during cycle t+j.
- `done_o` asserts in the cycle after the final GAP cycle; `busy_o` falls in the same cycle.
- Minimum spacing between WRITE commands is BurstLength+3 cycles plus the controller's ack latency.
- Stream words pass through the FIFO with 1 cycle of latency.

## Structure
- Shared package `sdram_pkg`:
  - command constants CMD_IDLE=2'b00, CMD_WRITE=2'b01, CMD_READ=2'b10;
  - address width constants (bank 2, row 13, column 10);
  - writer FSM state enum.
- Sub-module `sync_fifo` (DataWidth x FifoDepth, with occupancy count output), instantiated once.

## Test plan
- BurstLength=8, base 0x000100, count 1, stream 0x1111..0x8888 with no gaps. Required: exactly one WRITE at 0x000100, words appear in order one per cycle after the ack, `done_o` pulses once.
- Count 3, base 0x1FFFFFC with a model controller. Required: commands at 0x1FFFFFC, 0x0000004, 0x000000C (wraparound), with 24 words stored intact.
- Stream with `s_valid_i` toggling every other cycle. Required: no WRITE is issued until 8 words are buffered, and no words are lost or duplicated.
- Controller never acks. Required: `error_o`=1 at 15 cycles after CMD, FSM returns to IDLE, `done_o` stays 0, and the next start clears `error_o`.
- `rst_i` low during STREAM (word 4). Required: all outputs 0 in the same cycle; after release, a new transfer completes normally.
- `start_i` pulsed while busy, and count=0. Required: the busy pulse is ignored; count=0 gives `done_o` one cycle after start with no command.
